mont_exit: RTL
==============

MONT_EXIT -- requirements
Module: mont_exit

Interface
REQ-001 SHALL have parameter WIDTH, default 1024, operand/modulus width in bits; R = 2^WIDTH.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port N  input  WIDTH  modulus (odd), sampled with start.
REQ-006 SHALL have port A  input  WIDTH  Montgomery-form operand, A < N, sampled with start.
REQ-007 SHALL have port result  output  WIDTH  A*R^-1 mod N, registered, held until next completion or reset.
REQ-008 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port err  output  1  high with done when N was even; held until the next accepted start.

Function
REQ-011 SHALL compute result = A * R^-1 mod N, the exit from the Montgomery domain (inverse of the r/t constant entry path).
REQ-012 SHALL use bit-serial REDC: S = A; repeat WIDTH times {if S[0] then S = S + N; S = S >> 1}; then if S >= N then S = S - N.
REQ-013 SHALL hold S in WIDTH+1 bits so that S + N (< 2N) never overflows; the final compare uses the full WIDTH+1 bits.
REQ-014 SHALL implement states IDLE, LOOP, FINAL; IDLE->LOOP on start with N[0]=1; IDLE->FINAL on start with N[0]=0 (error path); LOOP->FINAL when the iteration counter reaches 0; FINAL->IDLE unconditionally.
REQ-015 SHALL load S, N and counter = WIDTH on the accepting edge and perform one iteration per clock in LOOP.
REQ-016 SHALL, in FINAL, write result, pulse done and clear busy on the same edge.
REQ-017 SHALL assert done exactly WIDTH+1 clocks after the start-accepting edge on the normal path, and 1 clock after it on the error path.
REQ-018 SHALL, on the error path, set result = 0 and err = 1.
REQ-019 SHALL ignore start while busy is high; in-flight operands are not disturbed.
REQ-020 SHALL accept start in the cycle immediately following done (back-to-back operation).
REQ-021 SHALL NOT check A < N; for A >= N the result is unspecified but the cycle timing is unchanged.

Reset
REQ-022 SHALL, with rst high at any edge including mid-operation, enter IDLE and set result = 0, busy = 0, done = 0, err = 0, and clear S and counter.
REQ-023 SHALL give rst priority over start when both are high on the same edge.

Structure
REQ-024 SHALL take RSA_WIDTH (1024) and the state encodings from the shared package rsa_pkg.
REQ-025 SHALL factor one REDC iteration (conditional add of N, right shift) into the combinational sub-module mont_red_step; all other logic stays in mont_exit.

Verification
REQ-026 WIDTH=8, N=13, A=1, start -> result=3, err=0, done exactly 9 clocks after the accept edge, busy high for the cycles in between.
REQ-027 WIDTH=8, N=13, A=9 (R mod N) -> result=1; A=12 -> result=10; A=0 -> result=0; run back-to-back, with start asserted in each cycle following done.
REQ-028 WIDTH=8, N=12 -> done 1 clock after accept, err=1, result=0; the next start with N=13, A=1 -> err=0, result=3.
REQ-029 WIDTH=8, N=13, A=1; assert rst 4 clocks after accept -> IDLE with all outputs 0 and no done pulse; a new start is then accepted; additionally, start re-pulsed while busy with different operands -> ignored, result=3.
REQ-030 WIDTH=1024, random odd N, random x < N; feed A = x*R mod N, computed from the r/t constants -> result = x; repeat for 100 seeds against the software model.

Source files
------------

// File: rtl/rsa_pkg.sv
// ---------------------------------------------------------------------------
// rsa_pkg
// Shared constants for the RSA datapath blocks.
//   RSA_WIDTH : default operand/modulus width in bits
//   ST_*      : state encodings of the Montgomery-exit controller
// ---------------------------------------------------------------------------
package rsa_pkg;

  localparam int RSA_WIDTH = 1024;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOOP  = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;

endpackage

// File: rtl/mont_exit_if.sv
// ---------------------------------------------------------------------------
// mont_exit_if
// Request/response bundle of the Montgomery-exit block.
//   start  : request pulse (master -> slave)
//   N, A   : modulus and Montgomery-form operand, sampled with start
//   result : A*R^-1 mod N, held until the next completion
//   busy   : operation in flight
//   done   : one-cycle completion pulse
//   err    : modulus was even (reported with done)
// ---------------------------------------------------------------------------
interface mont_exit_if #(
  parameter int WIDTH = rsa_pkg::RSA_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] N;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, N, A,
    input  result, busy, done, err
  );

  modport slave (
    input  start, N, A,
    output result, busy, done, err
  );

endinterface

// File: rtl/mont_red_step.sv
// ---------------------------------------------------------------------------
// mont_red_step
// One bit-serial REDC iteration, purely combinational:
//   o_s = (i_s + (i_s[0] ? i_n : 0)) >> 1
// Ports:
//   i_s : running value S, WIDTH+1 bits
//   i_n : modulus N, WIDTH bits
//   o_s : next S, WIDTH+1 bits
// ---------------------------------------------------------------------------
module mont_red_step
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic [WIDTH:0]   i_s,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH:0]   o_s
);

  logic [WIDTH+1:0] w_addend;
  logic [WIDTH+1:0] w_sum;

  // Adding N when S is odd makes the sum even, so the shift is exact.
  // One spare bit keeps the sum safe even for out-of-range operands.
  assign w_addend = i_s[0] ? {2'b00, i_n} : '0;
  assign w_sum    = {1'b0, i_s} + w_addend;
  assign o_s      = (WIDTH+1)'(w_sum >> 1);

endmodule

// File: rtl/mont_exit.sv
// ---------------------------------------------------------------------------
// mont_exit
// Leaves the Montgomery domain: result = A * R^-1 mod N, R = 2^WIDTH,
// using WIDTH bit-serial REDC iterations and a final conditional subtract.
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset (wins over start)
//   bus : mont_exit_if slave (start/N/A in, result/busy/done/err out)
// Timing: done rises WIDTH+1 clocks after the accepting edge, or 1 clock
// after it when N is even (err path, result forced to 0).
// ---------------------------------------------------------------------------
module mont_exit
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  mont_exit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]       r_state;
  logic [WIDTH:0]   r_s;
  logic [WIDTH-1:0] r_n;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic [WIDTH:0]   w_s_next;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;

  mont_red_step #(.WIDTH(WIDTH)) u_step (
    .i_s (r_s),
    .i_n (r_n),
    .o_s (w_s_next)
  );

  // Final correction compares all WIDTH+1 bits of S; when S >= N the true
  // difference is below N, so the truncated subtraction is exact.
  assign w_ge   = (r_s >= {1'b0, r_n});
  assign w_diff = r_s[WIDTH-1:0] - r_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_s      <= '0;
      r_n      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_s     <= {1'b0, bus.A};
            r_n     <= bus.N;
            r_cnt   <= CNT_W'(WIDTH);
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            // An even modulus has no inverse of R; skip straight to report.
            r_state <= bus.N[0] ? ST_LOOP : ST_FINAL;
          end
        end
        ST_LOOP: begin
          r_s   <= w_s_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          if (!r_n[0]) begin
            r_result <= '0;
            r_err    <= 1'b1;
          end else begin
            r_result <= w_ge ? w_diff : r_s[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.err    = r_err;

endmodule
